alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Holds issued ALU-class instructions (arithmetic, logic, shifts, compares, branches, JALR) until both operands are available.
- Snoops both CDB channels (ALU and load/store) to wake waiting operands.
- Dispatches one ready entry per cycle to the ALU over the val1/val2/flag/opcode/rob_reorder interface. It is the initiator side of that interface.
- Sits between the decoder/issue unit and the ALU.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_IDX_W, 4, log2(RS_SIZE).
- ROB_W, 4, ROB tag width (same as the `RBID range width).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous active-high reset.
- rdy_in  input  1  global ready; when low, all state holds.
- clear  input  1  misprediction flush.
- issue_flag  input  1  new instruction valid this cycle.
- issue_opcode  input  6  internal opcode (`ADD..`JALR encoding).
- issue_rob  input  ROB_W  destination ROB tag.
- issue_vj  input  32  operand 1 value, valid if issue_rj_rdy.
- issue_rj_rdy  input  1  operand 1 ready.
- issue_qj  input  ROB_W  operand 1 producer tag when not ready.
- issue_vk  input  32  operand 2 value or immediate, valid if issue_rk_rdy.
- issue_rk_rdy  input  1  operand 2 ready.
- issue_qk  input  ROB_W  operand 2 producer tag.
- rs_full  output  1  no free entry.
- alu_flag  output  1  dispatch valid; drives ALU flag.
- alu_val1  output  32  dispatched operand 1.
- alu_val2  output  32  dispatched operand 2.
- alu_opcode  output  6  dispatched opcode.
- alu_rob  output  ROB_W  dispatched ROB tag.
- cdb_alu_flag  input  1  ALU CDB broadcast valid.
- cdb_alu_rob  input  ROB_W  ALU CDB tag.
- cdb_alu_val  input  32  ALU CDB value.
- cdb_lsb_flag  input  1  LSB CDB broadcast valid.
- cdb_lsb_rob  input  ROB_W  LSB CDB tag.
- cdb_lsb_val  input  32  LSB CDB value.

Behaviour:
- Reset (asynchronous, rst_in=1): all entries' busy=0. alu_flag=0, alu_val1=0, alu_val2=0, alu_opcode=0, alu_rob=0. rs_full=0 (combinational from busy).
- Entry state: busy, opcode, rob, vj, rj_rdy, qj, vk, rk_rdy, qk.
- rs_full = all entries busy, computed from the registered busy vector.
- Issue: on a clk_in edge with rdy_in=1, clear=0, issue_flag=1 and a free entry, write the lowest-index free entry. Issue while rs_full=1 is ignored; the bench flags it as a protocol violation.
- Issue bypass: if an operand is not ready and its tag matches a valid CDB tag in the same cycle, capture the CDB value and mark it ready. If both CDBs match, the ALU CDB wins (this does not occur legally).
- Wakeup: every busy entry with rj_rdy=0 and qj==cdb_*_rob under cdb_*_flag captures vj and sets rj_rdy. The same applies to k. Both operands may wake in the same edge from different CDBs.
- Select: among entries busy with rj_rdy and rk_rdy in registered state at cycle start, pick the lowest index.
  - At the edge, register alu_flag=1 and copy vj→alu_val1, vk→alu_val2, opcode, rob. Clear that entry's busy.
  - If nothing is ready, alu_flag=0 and the data outputs hold their previous value.
- Wakeup-to-dispatch: an entry woken at edge t is eligible at edge t+1. Its result reaches the ALU inputs after edge t+1.
- Issue-to-dispatch: an instruction issued with both operands ready at edge t dispatches at edge t+1 and alu_flag is high during cycle t+1..t+2. Minimum latency 1 cycle.
- Same-edge issue and dispatch: a freed entry is not reusable until the next edge. The issue allocator uses the start-of-cycle busy vector.
- Throughput: 1 dispatch/cycle. alu_flag is a single-cycle pulse per instruction with no backpressure; the ALU always accepts.
- clear=1 (with rdy_in=1): all busy cleared and alu_flag=0 at that edge. clear overrides issue and dispatch in the same cycle.
- rdy_in=0: no state change, alu_flag forced 0 at the edge, and CDB inputs are ignored.
- Wrap/ordering: no age ordering is required. Lowest-index priority is the decided policy.

Test Plan:
- Reset mid-operation: 3 entries busy and alu_flag=1, assert rst_in asynchronously → alu_flag=0 and rs_full=0 immediately, before any clock edge; no dispatch after release.
- Ready issue: issue ADDI, vj=5, vk=7, rob=3, both ready at edge 0 → after edge 1: alu_flag=1, val1=5, val2=7, alu_rob=3; after edge 2: alu_flag=0.
- Wakeup: issue SUB with qj=2 not ready, vk=1 → no dispatch; at edge 4 cdb_lsb_flag=1, rob=2, val=0x10 → after edge 5: alu_val1=0x10, alu_val2=1.
- Same-cycle bypass: issue with qk=6 while cdb_alu_flag=1, rob=6, val=0xFFFF_FFFF → captured; dispatch with val2=0xFFFF_FFFF one cycle later.
- Full/priority: issue 16 not-ready entries → rs_full=1; a 17th issue is ignored; wake entries 9 and 2 in the same edge → entry 2 dispatches first, then entry 9; rs_full drops after the first dispatch.
- Flush: 5 busy entries plus issue_flag=1 and clear=1 → all busy=0, alu_flag=0 next cycle, later CDB traffic causes no dispatch.

Source files
------------

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers issued ALU-class ops, wakes operands from both
// CDBs and dispatches the lowest-index ready entry to the ALU once per cycle.
module alu_reservation_station #(
  parameter int unsigned RS_SIZE  = 16,
  parameter int unsigned RS_IDX_W = 4,
  parameter int unsigned ROB_W    = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              issue_flag,
  input  logic [5:0]        issue_opcode,
  input  logic [ROB_W-1:0]  issue_rob,
  input  logic [31:0]       issue_vj,
  input  logic              issue_rj_rdy,
  input  logic [ROB_W-1:0]  issue_qj,
  input  logic [31:0]       issue_vk,
  input  logic              issue_rk_rdy,
  input  logic [ROB_W-1:0]  issue_qk,
  output logic              rs_full,
  output logic              alu_flag,
  output logic [31:0]       alu_val1,
  output logic [31:0]       alu_val2,
  output logic [5:0]        alu_opcode,
  output logic [ROB_W-1:0]  alu_rob,
  input  logic              cdb_alu_flag,
  input  logic [ROB_W-1:0]  cdb_alu_rob,
  input  logic [31:0]       cdb_alu_val,
  input  logic              cdb_lsb_flag,
  input  logic [ROB_W-1:0]  cdb_lsb_rob,
  input  logic [31:0]       cdb_lsb_val
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 6;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   opcode;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] vj;
    logic              rj_rdy;
    logic [ROB_W-1:0]  qj;
    logic [DATA_W-1:0] vk;
    logic              rk_rdy;
    logic [ROB_W-1:0]  qk;
  } rs_entry_t;

  rs_entry_t         ent_q [RS_SIZE];
  rs_entry_t         ent_d [RS_SIZE];
  logic              alu_flag_q, alu_flag_d;
  logic [DATA_W-1:0] alu_val1_q, alu_val1_d;
  logic [DATA_W-1:0] alu_val2_q, alu_val2_d;
  logic [OP_W-1:0]   alu_opcode_q, alu_opcode_d;
  logic [ROB_W-1:0]  alu_rob_q, alu_rob_d;

  logic [RS_SIZE-1:0]  busy_vec;
  logic [RS_SIZE-1:0]  ready_vec;
  logic                free_vld;
  logic [RS_IDX_W-1:0] free_idx;
  logic                sel_vld;
  logic [RS_IDX_W-1:0] sel_idx;

  // A tag hit on either broadcast channel; the ALU channel takes priority on value.
  function automatic logic snoop_hit(input logic [ROB_W-1:0] tag);
    return (cdb_alu_flag && (cdb_alu_rob == tag)) || (cdb_lsb_flag && (cdb_lsb_rob == tag));
  endfunction

  function automatic logic [DATA_W-1:0] snoop_val(input logic [ROB_W-1:0] tag);
    return (cdb_alu_flag && (cdb_alu_rob == tag)) ? cdb_alu_val : cdb_lsb_val;
  endfunction

  // Lowest-index free slot and lowest-index ready slot, both from start-of-cycle state.
  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    free_vld  = 1'b0;
    free_idx  = '0;
    sel_vld   = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && ent_q[i].rj_rdy && ent_q[i].rk_rdy;
    end
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (!busy_vec[i]) begin
        free_vld = 1'b1;
        free_idx = RS_IDX_W'(i);
      end
      if (ready_vec[i]) begin
        sel_vld = 1'b1;
        sel_idx = RS_IDX_W'(i);
      end
    end
  end

  always_comb begin
    ent_d        = ent_q;
    alu_flag_d   = 1'b0;
    alu_val1_d   = alu_val1_q;
    alu_val2_d   = alu_val2_q;
    alu_opcode_d = alu_opcode_q;
    alu_rob_d    = alu_rob_q;
    if (rdy_in) begin
      if (clear) begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          ent_d[i].busy = 1'b0;
        end
      end else begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (ent_q[i].busy) begin
            if (!ent_q[i].rj_rdy && snoop_hit(ent_q[i].qj)) begin
              ent_d[i].vj     = snoop_val(ent_q[i].qj);
              ent_d[i].rj_rdy = 1'b1;
            end
            if (!ent_q[i].rk_rdy && snoop_hit(ent_q[i].qk)) begin
              ent_d[i].vk     = snoop_val(ent_q[i].qk);
              ent_d[i].rk_rdy = 1'b1;
            end
          end
        end
        if (sel_vld) begin
          alu_flag_d          = 1'b1;
          alu_val1_d          = ent_q[sel_idx].vj;
          alu_val2_d          = ent_q[sel_idx].vk;
          alu_opcode_d        = ent_q[sel_idx].opcode;
          alu_rob_d           = ent_q[sel_idx].rob;
          ent_d[sel_idx].busy = 1'b0;
        end
        // Allocation only sees slots free at cycle start, so it never collides with dispatch.
        if (issue_flag && free_vld) begin
          ent_d[free_idx].busy   = 1'b1;
          ent_d[free_idx].opcode = issue_opcode;
          ent_d[free_idx].rob    = issue_rob;
          ent_d[free_idx].qj     = issue_qj;
          ent_d[free_idx].qk     = issue_qk;
          if (!issue_rj_rdy && snoop_hit(issue_qj)) begin
            ent_d[free_idx].vj     = snoop_val(issue_qj);
            ent_d[free_idx].rj_rdy = 1'b1;
          end else begin
            ent_d[free_idx].vj     = issue_vj;
            ent_d[free_idx].rj_rdy = issue_rj_rdy;
          end
          if (!issue_rk_rdy && snoop_hit(issue_qk)) begin
            ent_d[free_idx].vk     = snoop_val(issue_qk);
            ent_d[free_idx].rk_rdy = 1'b1;
          end else begin
            ent_d[free_idx].vk     = issue_vk;
            ent_d[free_idx].rk_rdy = issue_rk_rdy;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent_q[i] <= '0;
      end
      alu_flag_q   <= 1'b0;
      alu_val1_q   <= '0;
      alu_val2_q   <= '0;
      alu_opcode_q <= '0;
      alu_rob_q    <= '0;
    end else begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent_q[i] <= ent_d[i];
      end
      alu_flag_q   <= alu_flag_d;
      alu_val1_q   <= alu_val1_d;
      alu_val2_q   <= alu_val2_d;
      alu_opcode_q <= alu_opcode_d;
      alu_rob_q    <= alu_rob_d;
    end
  end

  assign rs_full    = &busy_vec;
  assign alu_flag   = alu_flag_q;
  assign alu_val1   = alu_val1_q;
  assign alu_val2   = alu_val2_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_rob    = alu_rob_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_alu_reservation_station;

  localparam int unsigned RS_SIZE = 16;
  localparam int unsigned ROB_W   = 4;
  localparam logic [5:0]  OP_ADD  = 6'd1;
  localparam logic [5:0]  OP_SUB  = 6'd2;
  localparam logic [5:0]  OP_ADDI = 6'd10;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              rdy_in = 1'b1;
  logic              clear = 1'b0;
  logic              issue_flag = 1'b0;
  logic [5:0]        issue_opcode = '0;
  logic [ROB_W-1:0]  issue_rob = '0;
  logic [31:0]       issue_vj = '0;
  logic              issue_rj_rdy = 1'b0;
  logic [ROB_W-1:0]  issue_qj = '0;
  logic [31:0]       issue_vk = '0;
  logic              issue_rk_rdy = 1'b0;
  logic [ROB_W-1:0]  issue_qk = '0;
  logic              rs_full;
  logic              alu_flag;
  logic [31:0]       alu_val1;
  logic [31:0]       alu_val2;
  logic [5:0]        alu_opcode;
  logic [ROB_W-1:0]  alu_rob;
  logic              cdb_alu_flag = 1'b0;
  logic [ROB_W-1:0]  cdb_alu_rob = '0;
  logic [31:0]       cdb_alu_val = '0;
  logic              cdb_lsb_flag = 1'b0;
  logic [ROB_W-1:0]  cdb_lsb_rob = '0;
  logic [31:0]       cdb_lsb_val = '0;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  // Behavioural model: a table of waiting instructions plus the last dispatch.
  logic        m_busy [RS_SIZE];
  logic [5:0]  m_op   [RS_SIZE];
  logic [3:0]  m_rob  [RS_SIZE];
  logic [31:0] m_vj   [RS_SIZE];
  logic [31:0] m_vk   [RS_SIZE];
  logic        m_rj   [RS_SIZE];
  logic        m_rk   [RS_SIZE];
  logic [3:0]  m_qj   [RS_SIZE];
  logic [3:0]  m_qk   [RS_SIZE];
  logic        m_flag;
  logic [31:0] m_v1, m_v2;
  logic [5:0]  m_opc;
  logic [3:0]  m_arob;

  alu_reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_flag(issue_flag), .issue_opcode(issue_opcode), .issue_rob(issue_rob),
    .issue_vj(issue_vj), .issue_rj_rdy(issue_rj_rdy), .issue_qj(issue_qj),
    .issue_vk(issue_vk), .issue_rk_rdy(issue_rk_rdy), .issue_qk(issue_qk),
    .rs_full(rs_full), .alu_flag(alu_flag), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_opcode(alu_opcode), .alu_rob(alu_rob),
    .cdb_alu_flag(cdb_alu_flag), .cdb_alu_rob(cdb_alu_rob), .cdb_alu_val(cdb_alu_val),
    .cdb_lsb_flag(cdb_lsb_flag), .cdb_lsb_rob(cdb_lsb_rob), .cdb_lsb_val(cdb_lsb_val)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic model_full();
    for (int i = 0; i < int'(RS_SIZE); i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic cdb_has(input logic [3:0] tag);
    return (cdb_alu_flag && cdb_alu_rob == tag) || (cdb_lsb_flag && cdb_lsb_rob == tag);
  endfunction

  function automatic logic [31:0] cdb_get(input logic [3:0] tag);
    if (cdb_alu_flag && cdb_alu_rob == tag) return cdb_alu_val;
    return cdb_lsb_val;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      m_busy[i] = 1'b0; m_op[i] = '0; m_rob[i] = '0; m_vj[i] = '0; m_vk[i] = '0;
      m_rj[i] = 1'b0; m_rk[i] = 1'b0; m_qj[i] = '0; m_qk[i] = '0;
    end
    m_flag = 1'b0; m_v1 = '0; m_v2 = '0; m_opc = '0; m_arob = '0;
  endtask

  // One clock edge of the model, applied with the inputs present at that edge.
  task automatic model_step();
    int sel;
    int fr;
    sel = -1;
    fr  = -1;
    if (!rdy_in) begin
      m_flag = 1'b0;
      return;
    end
    if (clear) begin
      for (int i = 0; i < int'(RS_SIZE); i++) m_busy[i] = 1'b0;
      m_flag = 1'b0;
      return;
    end
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (sel < 0 && m_busy[i] && m_rj[i] && m_rk[i]) sel = i;
      if (fr < 0 && !m_busy[i]) fr = i;
    end
    m_flag = (sel >= 0);
    if (sel >= 0) begin
      m_v1 = m_vj[sel]; m_v2 = m_vk[sel]; m_opc = m_op[sel]; m_arob = m_rob[sel];
      m_busy[sel] = 1'b0;
    end
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (m_busy[i] && !m_rj[i] && cdb_has(m_qj[i])) begin m_vj[i] = cdb_get(m_qj[i]); m_rj[i] = 1'b1; end
      if (m_busy[i] && !m_rk[i] && cdb_has(m_qk[i])) begin m_vk[i] = cdb_get(m_qk[i]); m_rk[i] = 1'b1; end
    end
    if (issue_flag && fr >= 0) begin
      m_busy[fr] = 1'b1; m_op[fr] = issue_opcode; m_rob[fr] = issue_rob;
      m_qj[fr] = issue_qj; m_qk[fr] = issue_qk;
      m_rj[fr] = issue_rj_rdy || cdb_has(issue_qj);
      m_vj[fr] = (!issue_rj_rdy && cdb_has(issue_qj)) ? cdb_get(issue_qj) : issue_vj;
      m_rk[fr] = issue_rk_rdy || cdb_has(issue_qk);
      m_vk[fr] = (!issue_rk_rdy && cdb_has(issue_qk)) ? cdb_get(issue_qk) : issue_vk;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk_in) begin
    if (chk_en) begin
      check("alu_flag",   32'(alu_flag),   32'(m_flag));
      check("rs_full",    32'(rs_full),    32'(model_full()));
      check("alu_val1",   alu_val1,        m_v1);
      check("alu_val2",   alu_val2,        m_v2);
      check("alu_opcode", 32'(alu_opcode), 32'(m_opc));
      check("alu_rob",    32'(alu_rob),    32'(m_arob));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    if (!rst_in) model_step();
    @(negedge clk_in);
  endtask

  task automatic set_idle();
    rdy_in = 1'b1; clear = 1'b0; issue_flag = 1'b0;
    cdb_alu_flag = 1'b0; cdb_lsb_flag = 1'b0;
  endtask

  task automatic set_issue(input logic [5:0] op, input logic [3:0] rob,
                           input logic [31:0] vj, input logic rj, input logic [3:0] qj,
                           input logic [31:0] vk, input logic rk, input logic [3:0] qk);
    issue_flag = 1'b1; issue_opcode = op; issue_rob = rob;
    issue_vj = vj; issue_rj_rdy = rj; issue_qj = qj;
    issue_vk = vk; issue_rk_rdy = rk; issue_qk = qk;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("reset_flag", 32'(alu_flag), 32'd0);
    check("reset_full", 32'(rs_full), 32'd0);
    check("reset_val1", alu_val1, 32'd0);
    check("reset_val2", alu_val2, 32'd0);
    chk_en = 1'b1;
    @(negedge clk_in);

    // Ready issue dispatches one edge later as a single-cycle pulse.
    set_idle();
    set_issue(OP_ADDI, 4'd3, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0);
    tick();
    set_idle();
    tick();
    check("ready_flag", 32'(alu_flag), 32'd1);
    check("ready_val1", alu_val1, 32'd5);
    check("ready_val2", alu_val2, 32'd7);
    check("ready_rob",  32'(alu_rob), 32'd3);
    tick();
    check("ready_pulse_end", 32'(alu_flag), 32'd0);

    // Wakeup from the LSB CDB.
    set_issue(OP_SUB, 4'd4, 32'd0, 1'b0, 4'd2, 32'd1, 1'b1, 4'd0);
    tick();
    set_idle();
    tick();
    tick();
    check("wake_wait", 32'(alu_flag), 32'd0);
    cdb_lsb_flag = 1'b1; cdb_lsb_rob = 4'd2; cdb_lsb_val = 32'h10;
    tick();
    set_idle();
    check("wake_not_yet", 32'(alu_flag), 32'd0);
    tick();
    check("wake_flag", 32'(alu_flag), 32'd1);
    check("wake_val1", alu_val1, 32'h10);
    check("wake_val2", alu_val2, 32'd1);
    check("wake_op",   32'(alu_opcode), 32'(OP_SUB));

    // Same-cycle bypass from the ALU CDB during issue.
    set_issue(OP_ADD, 4'd5, 32'd3, 1'b1, 4'd0, 32'd0, 1'b0, 4'd6);
    cdb_alu_flag = 1'b1; cdb_alu_rob = 4'd6; cdb_alu_val = 32'hFFFF_FFFF;
    tick();
    set_idle();
    tick();
    check("bypass_flag", 32'(alu_flag), 32'd1);
    check("bypass_val2", alu_val2, 32'hFFFF_FFFF);
    check("bypass_rob",  32'(alu_rob), 32'd5);
    tick();

    // Fill all entries; entry i waits on tag i.
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      set_issue(OP_ADD, 4'(i), 32'd0, 1'b0, 4'(i), 32'(100 + i), 1'b1, 4'd0);
      tick();
    end
    set_idle();
    check("full_set", 32'(rs_full), 32'd1);
    set_issue(OP_SUB, 4'd14, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
    $display("[TB] note: deliberate issue while rs_full=1 (protocol violation, must be ignored)");
    tick();
    set_idle();
    check("full_ignored", 32'(rs_full), 32'd1);
    cdb_alu_flag = 1'b1; cdb_alu_rob = 4'd9; cdb_alu_val = 32'h99;
    cdb_lsb_flag = 1'b1; cdb_lsb_rob = 4'd2; cdb_lsb_val = 32'h22;
    tick();
    set_idle();
    check("prio_wait", 32'(alu_flag), 32'd0);
    tick();
    check("prio_first_rob",  32'(alu_rob), 32'd2);
    check("prio_first_val1", alu_val1, 32'h22);
    check("prio_first_val2", alu_val2, 32'd102);
    check("prio_full_drop",  32'(rs_full), 32'd0);
    tick();
    check("prio_second_rob",  32'(alu_rob), 32'd9);
    check("prio_second_val1", alu_val1, 32'h99);
    tick();
    check("prio_done", 32'(alu_flag), 32'd0);

    // Flush: drop leftovers, then five waiting entries flushed alongside an issue.
    clear = 1'b1;
    tick();
    set_idle();
    for (int i = 0; i < 5; i++) begin
      set_issue(OP_ADD, 4'(i), 32'd0, 1'b0, 4'(10 + i), 32'd0, 1'b1, 4'd0);
      tick();
    end
    set_issue(OP_ADDI, 4'd8, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0);
    clear = 1'b1;
    tick();
    set_idle();
    check("flush_flag", 32'(alu_flag), 32'd0);
    check("flush_full", 32'(rs_full), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cdb_alu_flag = 1'b1; cdb_alu_rob = 4'(10 + i); cdb_alu_val = 32'(i);
      tick();
    end
    set_idle();
    tick();
    check("flush_no_dispatch", 32'(alu_flag), 32'd0);

    // Asynchronous reset with entries busy and a dispatch in flight.
    for (int i = 0; i < 3; i++) begin
      set_issue(OP_SUB, 4'(i), 32'd0, 1'b0, 4'd15, 32'd0, 1'b1, 4'd0);
      tick();
    end
    set_issue(OP_ADD, 4'd7, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0);
    tick();
    set_idle();
    tick();
    check("pre_reset_flag", 32'(alu_flag), 32'd1);
    #2;
    rst_in = 1'b1;
    model_reset();
    #1;
    check("async_reset_flag", 32'(alu_flag), 32'd0);
    check("async_reset_full", 32'(rs_full), 32'd0);
    @(negedge clk_in);
    tick();
    rst_in = 1'b0;
    cdb_alu_flag = 1'b1; cdb_alu_rob = 4'd15; cdb_alu_val = 32'h5;
    tick();
    set_idle();
    tick();
    check("post_reset_idle", 32'(alu_flag), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      rdy_in       = ($urandom_range(0, 9) != 0);
      clear        = ($urandom_range(0, 63) == 0);
      issue_flag   = !model_full() && ($urandom_range(0, 1) == 1);
      issue_opcode = 6'($urandom);
      issue_rob    = 4'($urandom);
      issue_vj     = $urandom;
      issue_rj_rdy = 1'($urandom_range(0, 1));
      issue_qj     = 4'($urandom);
      issue_vk     = $urandom;
      issue_rk_rdy = 1'($urandom_range(0, 1));
      issue_qk     = 4'($urandom);
      cdb_alu_flag = 1'($urandom_range(0, 1));
      cdb_alu_rob  = 4'($urandom);
      cdb_alu_val  = $urandom;
      cdb_lsb_flag = 1'($urandom_range(0, 1));
      cdb_lsb_rob  = 4'($urandom);
      cdb_lsb_val  = $urandom;
      if (cdb_alu_flag && cdb_lsb_flag && cdb_alu_rob == cdb_lsb_rob) cdb_lsb_rob = cdb_alu_rob + 4'd1;
      tick();
    end
    set_idle();
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
